// File: rtl/sseg_pkg.sv
// Shared types, glyph constants and the nibble-to-segment decoder for the
// multiplexed seven-segment display controller.
package sseg_pkg;

    // Display number base selected at LOAD time
    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_DEC = 1'b1
    } mode_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // Hex glyph lookup: 0-9, A, b, C, d, E, F
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock for
// DATA_W clocks. done_o marks the final step; bcd_o/ovf_o carry that step's
// result combinationally so the caller can commit on the same edge busy falls.
module bin2bcd_seq
    import sseg_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [DATA_W-1:0]       bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    ovf_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              busy_q, busy_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [BCD_W-1:0]  adj_s;
    logic [BCD_W-1:0]  bcd_step_s;
    logic              ovf_step_s;
    logic              last_s;

    // One double-dabble step: add 3 to every digit >= 5, then shift left by one
    always_comb begin
        adj_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
        bcd_step_s = {adj_s[BCD_W-2:0], bin_q[DATA_W-1]};
        // A 1 leaving the top digit means the value needs more digits than exist
        ovf_step_s = ovf_q | adj_s[BCD_W-1];
        last_s     = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
    end

    // Next-state: start loads operand, busy advances one step per cycle
    always_comb begin
        busy_d = busy_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        if (busy_q) begin
            bin_d = {bin_q[DATA_W-2:0], 1'b0};
            bcd_d = bcd_step_s;
            ovf_d = ovf_step_s;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_s) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else if (start_i) begin
            busy_d = 1'b1;
            bin_d  = bin_i;
            bcd_d  = '0;
            ovf_d  = 1'b0;
            cnt_d  = '0;
        end else begin
            busy_d = 1'b0;
        end
    end

    // Conversion state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            bin_q  <= '0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = last_s;
    assign bcd_o  = bcd_step_s;
    assign ovf_o  = ovf_step_s;

endmodule

// File: rtl/sseg_display_ctrl.sv
// Multiplexed seven-segment controller: latches a value, shows it in hex or
// decimal with leading-zero blanking, per-digit DP and "----" overflow, and
// scans the digits with registered active-low segment/enable outputs.
module sseg_display_ctrl
    import sseg_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_W-1:0]     value_i,
    input  logic                  load_i,
    input  logic                  mode_i,
    input  logic                  blank_lz_i,
    input  logic [NUM_DIGITS-1:0] dp_mask_i,
    output logic                  busy_o,
    output logic [7:0]            sseg_o,
    output logic [NUM_DIGITS-1:0] disp_en_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Committed display state
    logic [BCD_W-1:0]      shown_q, shown_d;
    logic                  ovf_q, ovf_d;
    logic                  blank_q, blank_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
    // Options captured with a decimal LOAD, applied when its result commits
    logic                  pend_blank_q, pend_blank_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    // Scan state and output registers
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            sseg_q, sseg_d;
    logic [NUM_DIGITS-1:0] disp_en_q, disp_en_d;

    logic                     busy_s;
    logic                     done_s;
    logic [BCD_W-1:0]         bcd_s;
    logic                     bcd_ovf_s;
    logic                     accept_s;
    logic                     start_s;
    mode_t                    mode_s;
    logic [DATA_W+BCD_W-1:0]  value_ext_s;
    logic                     hex_ovf_s;
    logic [NUM_DIGITS-1:0]    blank_s;
    logic                     zero_above_s;
    logic [6:0]               glyph_s;

    assign mode_s      = mode_t'(mode_i);
    assign accept_s    = load_i && !busy_s;
    assign start_s     = accept_s && (mode_s == MODE_DEC);
    assign value_ext_s = {{BCD_W{1'b0}}, value_i};
    assign hex_ovf_s   = |(value_ext_s >> BCD_W);

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_s),
        .bin_i   (value_i),
        .busy_o  (busy_s),
        .done_o  (done_s),
        .bcd_o   (bcd_s),
        .ovf_o   (bcd_ovf_s)
    );

    // Capture: hex loads update the display at once, decimal loads on commit
    always_comb begin
        shown_d      = shown_q;
        ovf_d        = ovf_q;
        blank_d      = blank_q;
        dp_d         = dp_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        if (done_s) begin
            shown_d = bcd_s;
            ovf_d   = bcd_ovf_s;
            blank_d = pend_blank_q;
            dp_d    = pend_dp_q;
        end else if (accept_s) begin
            if (mode_s == MODE_DEC) begin
                pend_blank_d = blank_lz_i;
                pend_dp_d    = dp_mask_i;
            end else begin
                shown_d = value_ext_s[BCD_W-1:0];
                ovf_d   = hex_ovf_s;
                blank_d = blank_lz_i;
                dp_d    = dp_mask_i;
            end
        end else begin
            shown_d = shown_q;
        end
    end

    // Refresh counter and scan index; index advances at terminal count
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Leading-zero blanking: digits above the highest nonzero one, never digit 0
    always_comb begin
        zero_above_s = 1'b1;
        blank_s      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above_s = zero_above_s && (shown_q[4*i +: 4] == 4'h0);
            if ((i != 0) && zero_above_s && blank_q && !ovf_q) begin
                blank_s[i] = 1'b1;
            end else begin
                blank_s[i] = 1'b0;
            end
        end
    end

    // Segment pattern and one-hot-low enable for the currently scanned digit
    always_comb begin
        if (ovf_q) begin
            glyph_s = SEG_DASH;
        end else if (blank_s[idx_q]) begin
            glyph_s = SEG_BLANK;
        end else begin
            glyph_s = seg_decode(shown_q[4*idx_q +: 4]);
        end
        sseg_d    = {~dp_q[idx_q], glyph_s};
        disp_en_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shown_q      <= '0;
            ovf_q        <= 1'b0;
            blank_q      <= 1'b0;
            dp_q         <= '0;
            pend_blank_q <= 1'b0;
            pend_dp_q    <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            sseg_q       <= 8'hFF;
            disp_en_q    <= '1;
        end else begin
            shown_q      <= shown_d;
            ovf_q        <= ovf_d;
            blank_q      <= blank_d;
            dp_q         <= dp_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sseg_q       <= sseg_d;
            disp_en_q    <= disp_en_d;
        end
    end

    assign busy_o    = busy_s;
    assign sseg_o    = sseg_q;
    assign disp_en_o = disp_en_q;

endmodule

// File: tb/tb_sseg_display_ctrl.sv
// Directed bench for sseg_display_ctrl (DATA_W=16, NUM_DIGITS=4,
// REFRESH_DIV=4) plus a DATA_W=20 instance for hex overflow.
module tb_sseg_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        mode;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic        busy;
    logic [7:0]  sseg;
    logic [3:0]  disp_en;

    logic [19:0] value20;
    logic        load20;
    logic        mode20;
    logic        blank20;
    logic [3:0]  dp20;
    logic        busy20;
    logic [7:0]  sseg20;
    logic [3:0]  disp_en20;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sseg_display_ctrl #(.DATA_W(16), .NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .value_i(value), .load_i(load),
        .mode_i(mode), .blank_lz_i(blank_lz), .dp_mask_i(dp_mask),
        .busy_o(busy), .sseg_o(sseg), .disp_en_o(disp_en)
    );

    sseg_display_ctrl #(.DATA_W(20), .NUM_DIGITS(4), .REFRESH_DIV(4)) dut20 (
        .clk_i(clk), .rst_ni(rst_n), .value_i(value20), .load_i(load20),
        .mode_i(mode20), .blank_lz_i(blank20), .dp_mask_i(dp20),
        .busy_o(busy20), .sseg_o(sseg20), .disp_en_o(disp_en20)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Wait (bounded) until digit d is enabled and return its segments
    task automatic get_digit(input int d, output logic [7:0] seg);
        logic [3:0] one;
        logic [3:0] want;
        bit         found;
        one   = 4'b0001;
        want  = ~(one << d);
        found = 1'b0;
        seg   = 8'h00;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (disp_en === want) begin
                found = 1'b1;
                seg   = sseg;
            end
        end
        if (!found) check_eq($sformatf("digit%0d_timeout", d), 32'd0, 32'd1);
    endtask

    // exp packs {digit3, digit2, digit1, digit0}
    task automatic expect_digits(input string tag, input logic [31:0] exp);
        logic [7:0] s;
        for (int d = 0; d < 4; d++) begin
            get_digit(d, s);
            check_eq($sformatf("%s_d%0d", tag, d), {24'd0, s}, {24'd0, exp[8*d +: 8]});
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic m, input logic b, input logic [3:0] dp);
        @(negedge clk);
        value    = v;
        mode     = m;
        blank_lz = b;
        dp_mask  = dp;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Count negedges with BUSY high (called at first busy negedge)
    task automatic wait_busy_fall(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int         n;
        int         bad;
        bit         found;
        logic [3:0] one;
        logic [3:0] want;

        rst_n = 1'b0; value = 16'd0; load = 1'b0; mode = 1'b0;
        blank_lz = 1'b0; dp_mask = 4'd0;
        value20 = 20'd0; load20 = 1'b0; mode20 = 1'b0; blank20 = 1'b0; dp20 = 4'd0;
        one = 4'b0001;

        // 1 Reset and scan sequence
        repeat (3) @(negedge clk);
        check_eq("rst_sseg", {24'd0, sseg}, 32'hFF);
        check_eq("rst_en", {28'd0, disp_en}, 32'hF);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_sseg20", {24'd0, sseg20}, 32'hFF);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            want = ~(one << ((k - 1) / 4));
            check_eq($sformatf("scan_%0d", k), {28'd0, disp_en}, {28'd0, want});
            if (k == 1) check_eq("rst_digit0", {24'd0, sseg}, 32'hC0);
        end

        // 2 Hex with and without blanking
        do_load(16'h00A5, 1'b0, 1'b1, 4'd0);
        expect_digits("hex_blank", 32'hFFFF8892);
        do_load(16'h00A5, 1'b0, 1'b0, 4'd0);
        expect_digits("hex_noblank", 32'hC0C08892);

        // 3 Decimal 255: 16 busy cycles, old display held until commit
        do_load(16'd255, 1'b1, 1'b1, 4'd0);
        n = 0;
        bad = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (disp_en === 4'hD && sseg !== 8'h88) bad++;
            if (disp_en === 4'h7 && sseg !== 8'hC0) bad++;
            @(negedge clk);
        end
        check_eq("dec_busy_len", n, 32'd16);
        check_eq("dec_hold", bad, 32'd0);
        expect_digits("dec255", 32'hFFA49292);

        // 4 Overflow: decimal and hex on the wide instance
        do_load(16'd12345, 1'b1, 1'b0, 4'd0);
        wait_busy_fall(n);
        check_eq("ovf_busy_len", n, 32'd16);
        expect_digits("dec_ovf", 32'hBFBFBFBF);
        @(negedge clk);
        value20 = 20'h10000;
        load20  = 1'b1;
        @(negedge clk);
        load20  = 1'b0;
        @(negedge clk);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (disp_en20 === 4'hE) begin
                found = 1'b1;
                check_eq("hex_ovf20", {24'd0, sseg20}, 32'hBF);
            end
        end
        if (!found) check_eq("hex_ovf20_timeout", 32'd0, 32'd1);

        // 5 LOAD during conversion is ignored
        do_load(16'd255, 1'b1, 1'b1, 4'd0);
        n = 1;
        repeat (3) @(negedge clk);
        n = n + 3;
        value = 16'd7; mode = 1'b1; blank_lz = 1'b0; dp_mask = 4'hF;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        n = n + 1;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        check_eq("ign_busy_len", n - 1, 32'd16);
        expect_digits("ign_load", 32'hFFA49292);

        // 6 Reset mid-conversion, then DP mask
        do_load(16'd255, 1'b1, 1'b1, 4'd0);
        repeat (7) @(negedge clk);
        check_eq("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_sseg", {24'd0, sseg}, 32'hFF);
        check_eq("abort_en", {28'd0, disp_en}, 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (24) @(negedge clk);
        check_eq("abort_no_busy", {31'd0, busy}, 32'd0);
        expect_digits("abort_zero", 32'hC0C0C0C0);
        do_load(16'h0000, 1'b0, 1'b0, 4'b0010);
        expect_digits("dp_mask", 32'hC0C040C0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
